recur_controller: RTL and testbench

Sequencing FSM for the recurrence datapath computing f(n) = 2·f(n-1) + 3·f(n-2), with f(0) = f(1) = 1.
- Accepts a request through a start/ready handshake.
- Drives the datapath's one-hot control strobes through the init / evaluate / push / calculate / pop loop until the datapath reports `done`.
- Reports completion, run length and optional watchdog abort.
- Sits directly above the datapath. All datapath control and status pass through this block.

---
 rtl/recur_controller_if.sv | 53 +++++
 rtl/recur_controller.sv | 190 +++++++++++++++++++
 tb/tb_recur_controller.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/recur_controller_if.sv
//------------------------------------------------------------------------------
// recur_controller_if
//   Bundles the request handshake, the run report and the datapath
//   control/status lines of the recurrence controller.
//
//   Request side : start, entry_in (to controller); ready (from controller)
//   Report side  : valid, error, cycles, entry (from controller)
//   Datapath side: load_init, alu, updater, cal_res, poping, res_updater
//                  (controller strobes); updated, done, backtrack,
//                  cal_update (datapath status)
//
//   Modports:
//     slave  - the controller's view
//     master - the view of whatever drives requests and the datapath status
//------------------------------------------------------------------------------
`timescale 1ns/1ps

interface recur_controller_if #(
  parameter int SIZE  = 4,
  parameter int CNT_W = 16
);
  logic             start;
  logic [SIZE-1:0]  entry_in;
  logic             ready;
  logic             valid;
  logic             error;
  logic [CNT_W-1:0] cycles;
  logic [SIZE-1:0]  entry;

  logic             load_init;
  logic             alu;
  logic             updater;
  logic             cal_res;
  logic             poping;
  logic             res_updater;

  logic             updated;
  logic             done;
  logic             backtrack;
  logic             cal_update;

  modport slave (
    input  start, entry_in, updated, done, backtrack, cal_update,
    output ready, valid, error, cycles, entry,
           load_init, alu, updater, cal_res, poping, res_updater
  );

  modport master (
    output start, entry_in, updated, done, backtrack, cal_update,
    input  ready, valid, error, cycles, entry,
           load_init, alu, updater, cal_res, poping, res_updater
  );
endinterface

// File: rtl/recur_controller.sv
//------------------------------------------------------------------------------
// recur_controller
//   Sequencing FSM for the recurrence datapath f(n) = 2*f(n-1) + 3*f(n-2),
//   f(0) = f(1) = 1. Accepts a request on start/ready, steps the datapath
//   through init / evaluate / push / calculate / pop until it reports done,
//   then pulses valid and reports the run length in cycles.
//
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous, active-low reset
//     bus  - recur_controller_if.slave (handshake, report, datapath strobes
//            and status)
//
//   Parameters:
//     SIZE    - entry width (matches the datapath)
//     CNT_W   - run-length counter width
//     TIMEOUT - watchdog limit in non-idle cycles
//
//   Optional feature macro: CTRL_TIMEOUT_EN
//     Defined   : watchdog aborts a run to IDLE with error set once the run
//                 has spent TIMEOUT non-idle cycles.
//     Undefined : no watchdog, error tied low, TIMEOUT unused.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module recur_controller #(
  parameter int SIZE    = 4,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  recur_controller_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    EVAL,
    PUSH,
    CALC,
    CHECK,
    POP,
    RESN,
    FIN
  } state_t;

  state_t           r_state;
  state_t           w_next;

  // r_count holds the number of non-idle cycles of the current run,
  // including the cycle in progress (1 in INIT).
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_countInc;
  logic [CNT_W-1:0] r_cycles;
  logic [SIZE-1:0]  r_entry;

  logic             r_ready;
  logic             r_valid;
  logic             r_loadInit;
  logic             r_alu;
  logic             r_updater;
  logic             r_calRes;
  logic             r_poping;
  logic             r_resUpdater;

  // updated and cal_update are informational only and never steer the FSM.
  logic             w_unusedStatus;
  assign w_unusedStatus = bus.updated ^ bus.cal_update;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  assign w_countInc = (&r_count) ? r_count : r_count + 1'b1;

`ifdef CTRL_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT);

  logic r_error;
  logic w_timeout;

  // FIN is excluded so a run that finishes on the limit still reports valid.
  assign w_timeout = (r_state != IDLE) && (r_state != FIN) &&
                     (r_count == TIMEOUT_VAL);
`else
  localparam int unusedTimeout = TIMEOUT;
`endif

  // Next-state selection; the watchdog, when present, overrides the normal
  // transition and drops the run straight back to IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = INIT;
      INIT:    w_next = EVAL;
      EVAL: begin
        if (r_entry < SIZE'(2))
          w_next = FIN;
        else if (bus.backtrack)
          w_next = CALC;
        else
          w_next = PUSH;
      end
      PUSH:    w_next = EVAL;
      CALC:    w_next = CHECK;
      CHECK:   w_next = bus.done ? FIN : POP;
      POP:     w_next = RESN;
      RESN:    w_next = EVAL;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
`ifdef CTRL_TIMEOUT_EN
    if (w_timeout) w_next = IDLE;
`endif
  end

  // State, run bookkeeping and registered outputs. Every output is decoded
  // from the state being entered so it is high exactly while that state is
  // current, and never glitches between strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_ready      <= 1'b1;
      r_valid      <= 1'b0;
      r_loadInit   <= 1'b0;
      r_alu        <= 1'b0;
      r_updater    <= 1'b0;
      r_calRes     <= 1'b0;
      r_poping     <= 1'b0;
      r_resUpdater <= 1'b0;
      r_count      <= '0;
      r_cycles     <= '0;
      r_entry      <= '0;
    end else begin
      r_state      <= w_next;
      r_ready      <= (w_next == IDLE);
      r_valid      <= (w_next == FIN);
      r_loadInit   <= (w_next == INIT);
      r_alu        <= (w_next == EVAL);
      r_updater    <= (w_next == PUSH);
      r_calRes     <= (w_next == CALC);
      r_poping     <= (w_next == POP);
      r_resUpdater <= (w_next == RESN);

      if (r_state == IDLE) begin
        if (bus.start) begin
          r_entry <= bus.entry_in;
          r_count <= CNT_W'(1);
        end
      end else begin
        r_count <= w_countInc;
      end

      // Publishing on entry to FIN makes cycles readable alongside valid;
      // the incremented value already counts the FIN cycle itself.
      if (w_next == FIN) r_cycles <= w_countInc;
`ifdef CTRL_TIMEOUT_EN
      if (w_timeout) r_cycles <= TIMEOUT_VAL;
`endif
    end
  end

`ifdef CTRL_TIMEOUT_EN
  // Sticky abort flag: raised together with the forced return to IDLE and
  // cleared only by the next accepted request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_error <= 1'b0;
    end else if (w_timeout) begin
      r_error <= 1'b1;
    end else if (r_state == IDLE && bus.start) begin
      r_error <= 1'b0;
    end
  end

  assign bus.error = r_error;
`else
  assign bus.error = 1'b0;
`endif

  assign bus.ready       = r_ready;
  assign bus.valid       = r_valid;
  assign bus.cycles      = r_cycles;
  assign bus.entry       = r_entry;
  assign bus.load_init   = r_loadInit;
  assign bus.alu         = r_alu;
  assign bus.updater     = r_updater;
  assign bus.cal_res     = r_calRes;
  assign bus.poping      = r_poping;
  assign bus.res_updater = r_resUpdater;

endmodule

// File: tb/tb_recur_controller.sv
//------------------------------------------------------------------------------
// tb_recur_controller
//   Drives recur_controller with a small behavioural datapath that walks the
//   recurrence on a counting stack, and compares each run against closed-form
//   expectations for result, run length and strobe counts.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_recur_controller;

  localparam int SIZE    = 4;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 255;

  logic clk;
  logic rst;
  logic stuck;

  int assertCount;
  int failCount;

  recur_controller_if #(.SIZE(SIZE), .CNT_W(CNT_W)) bus ();

  recur_controller #(
    .SIZE    (SIZE),
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural datapath: descends n by pushes until n<2, then climbs back
  // one level per pop, keeping (f(k), f(k-1)). When stuck, it never reports
  // backtrack or done so the controller can only loop.
  int   dpN;
  int   dpDepth;
  int   dpFk;
  int   dpFkm1;
  int   dpResult;
  logic noiseA;
  logic noiseB;

  assign bus.backtrack  = stuck ? 1'b0 : (dpN < 2);
  assign bus.done       = stuck ? 1'b0 : (dpDepth == 0);
  assign bus.updated    = noiseA;
  assign bus.cal_update = noiseB;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      dpN      <= 0;
      dpDepth  <= 0;
      dpFk     <= 1;
      dpFkm1   <= 1;
      dpResult <= 0;
      noiseA   <= 1'b0;
      noiseB   <= 1'b0;
    end else begin
      noiseA <= 1'($urandom_range(0, 1));
      noiseB <= 1'($urandom_range(0, 1));
      if (bus.load_init) begin
        dpN      <= int'(bus.entry);
        dpDepth  <= 0;
        dpFk     <= 1;
        dpFkm1   <= 1;
        dpResult <= 1;
      end
      if (bus.updater) begin
        dpDepth <= dpDepth + 1;
        dpN     <= dpN - 1;
      end
      if (bus.cal_res) dpResult <= dpFk;
      if (bus.poping) dpDepth <= dpDepth - 1;
      if (bus.res_updater) begin
        dpFk   <= 2 * dpFk + 3 * dpFkm1;
        dpFkm1 <= dpFk;
      end
    end
  end

  // Reference model
  function automatic int refF(input int n);
    int a;
    int b;
    int t;
    a = 1;
    b = 1;
    for (int i = 2; i <= n; i++) begin
      t = 2 * a + 3 * b;
      b = a;
      a = t;
    end
    return a;
  endfunction

  // INIT + (n-1) push pairs + (n-1) five-cycle backtracks + final
  // three-cycle backtrack + FIN.
  function automatic int refCycles(input int n);
    if (n < 2) return 3;
    return 1 + 2 * (n - 1) + 5 * (n - 1) + 3 + 1;
  endfunction

  function automatic int strobeSum();
    return int'(bus.load_init) + int'(bus.alu) + int'(bus.updater) +
           int'(bus.cal_res) + int'(bus.poping) + int'(bus.res_updater);
  endfunction

  // One complete run starting from an IDLE negedge; optionally pulses a
  // foreign start (entry_in=7) at cycle intrudeAt while busy.
  task automatic runOne(input int n, input int intrudeAt, input string tag);
    int validCount, validAt, gotResult, gotCycles, readyAtValid, readyAfter;
    int multiHot, entryBad;
    int loadCnt, aluCnt, updCnt, calCnt, popCnt, resCnt;
    int expAlu, expUpd, expCal, expPop, expRes;
    validCount = 0; validAt = -1; gotResult = -1; gotCycles = -1;
    readyAtValid = -1; readyAfter = -1; multiHot = 0; entryBad = 0;
    loadCnt = 0; aluCnt = 0; updCnt = 0; calCnt = 0; popCnt = 0; resCnt = 0;

    assertCount++;
    if (bus.ready !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL %s ready_before_start: got %b want 1", tag, bus.ready);
    end

    bus.start    = 1'b1;
    bus.entry_in = SIZE'(n);
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.start    = 1'b0;
        bus.entry_in = SIZE'($urandom_range(0, 15));
      end
      if (intrudeAt > 0 && k == intrudeAt) begin
        bus.start    = 1'b1;
        bus.entry_in = SIZE'(7);
      end
      if (intrudeAt > 0 && k == intrudeAt + 1) bus.start = 1'b0;
      if (strobeSum() > 1) multiHot++;
      if (bus.entry !== SIZE'(n)) entryBad++;
      loadCnt += int'(bus.load_init);
      aluCnt  += int'(bus.alu);
      updCnt  += int'(bus.updater);
      calCnt  += int'(bus.cal_res);
      popCnt  += int'(bus.poping);
      resCnt  += int'(bus.res_updater);
      if (validCount > 0 && k == validAt + 1) begin
        readyAfter = int'(bus.ready);
        break;
      end
      if (bus.valid === 1'b1) begin
        validCount++;
        if (validAt < 0) begin
          validAt      = k;
          gotResult    = dpResult;
          gotCycles    = int'(bus.cycles);
          readyAtValid = int'(bus.ready);
        end
      end
    end
    bus.start = 1'b0;

    expAlu = (n < 2) ? 1 : 2 * n - 1;
    expUpd = (n < 2) ? 0 : n - 1;
    expCal = (n < 2) ? 0 : n;
    expPop = (n < 2) ? 0 : n - 1;
    expRes = (n < 2) ? 0 : n - 1;

    assertCount++;
    if (validCount !== 1) begin
      failCount++;
      $display("[TB] FAIL %s valid_count: got %0d want 1", tag, validCount);
    end
    assertCount++;
    if (validAt !== refCycles(n)) begin
      failCount++;
      $display("[TB] FAIL %s valid_cycle: got %0d want %0d", tag, validAt, refCycles(n));
    end
    assertCount++;
    if (gotCycles !== refCycles(n)) begin
      failCount++;
      $display("[TB] FAIL %s cycles: got %0d want %0d", tag, gotCycles, refCycles(n));
    end
    assertCount++;
    if (gotResult !== refF(n)) begin
      failCount++;
      $display("[TB] FAIL %s result: got %0d want %0d", tag, gotResult, refF(n));
    end
    assertCount++;
    if (readyAtValid !== 0 || readyAfter !== 1) begin
      failCount++;
      $display("[TB] FAIL %s ready_around_valid: got %0d/%0d want 0/1", tag, readyAtValid, readyAfter);
    end
    assertCount++;
    if (multiHot !== 0) begin
      failCount++;
      $display("[TB] FAIL %s strobe_onehot: got %0d multi-hot cycles want 0", tag, multiHot);
    end
    assertCount++;
    if (entryBad !== 0) begin
      failCount++;
      $display("[TB] FAIL %s entry_hold: got %0d bad cycles want 0", tag, entryBad);
    end
    assertCount++;
    if (loadCnt !== 1 || aluCnt !== expAlu || updCnt !== expUpd ||
        calCnt !== expCal || popCnt !== expPop || resCnt !== expRes) begin
      failCount++;
      $display("[TB] FAIL %s strobe_counts: got %0d/%0d/%0d/%0d/%0d/%0d want 1/%0d/%0d/%0d/%0d/%0d",
               tag, loadCnt, aluCnt, updCnt, calCnt, popCnt, resCnt,
               expAlu, expUpd, expCal, expPop, expRes);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    assertCount++;
    if (bus.ready !== 1'b1 || bus.valid !== 1'b0 || bus.error !== 1'b0 || strobeSum() !== 0) begin
      failCount++;
      $display("[TB] FAIL reset_flags: got ready=%b valid=%b error=%b strobes=%0d want 1/0/0/0",
               bus.ready, bus.valid, bus.error, strobeSum());
    end
    assertCount++;
    if (bus.cycles !== '0 || bus.entry !== '0) begin
      failCount++;
      $display("[TB] FAIL reset_regs: got cycles=%0d entry=%0d want 0/0", bus.cycles, bus.entry);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_entry_zero();
    int badOther;
    badOther = 0;
    bus.start    = 1'b1;
    bus.entry_in = '0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.updater || bus.cal_res || bus.poping) badOther++;
      if (k == 1) begin
        assertCount++;
        if (bus.load_init !== 1'b1) begin
          failCount++;
          $display("[TB] FAIL zero_load_init_c1: got %b want 1", bus.load_init);
        end
      end
      if (k == 2) begin
        assertCount++;
        if (bus.alu !== 1'b1) begin
          failCount++;
          $display("[TB] FAIL zero_alu_c2: got %b want 1", bus.alu);
        end
      end
      if (k == 3) begin
        assertCount++;
        if (bus.valid !== 1'b1 || bus.cycles !== CNT_W'(3)) begin
          failCount++;
          $display("[TB] FAIL zero_valid_c3: got valid=%b cycles=%0d want 1/3", bus.valid, bus.cycles);
        end
      end
    end
    assertCount++;
    if (badOther !== 0 || bus.ready !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL zero_no_push_and_idle: got bad=%0d ready=%b want 0/1", badOther, bus.ready);
    end
  endtask

  task automatic test_sequence();
    runOne(2, 0, "seq2");
    runOne(3, 0, "seq3");
    runOne(4, 0, "seq4");
  endtask

  task automatic test_busy_start();
    runOne(4, 5, "busy");
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) runOne(int'($urandom_range(0, 15)), 0, "rand");
  endtask

  task automatic test_back_to_back();
    int bad;
    bad = 0;
    bus.start    = 1'b1;
    bus.entry_in = SIZE'(1);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 16) bus.start = 1'b0;
      assertCount++;
      if (bus.valid !== ((i % 4) == 3) || bus.ready !== ((i % 4) == 0)) begin
        failCount++;
        $display("[TB] FAIL b2b_cycle%0d: got valid=%b ready=%b want %b/%b",
                 i, bus.valid, bus.ready, (i % 4) == 3, (i % 4) == 0);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_push();
    bit found;
    found = 1'b0;
    bus.start    = 1'b1;
    bus.entry_in = SIZE'(6);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.updater === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    assertCount++;
    if (!found) begin
      failCount++;
      $display("[TB] FAIL midpush_reached: got 0 want 1");
    end
    #2 rst = 1'b0;
    #1;
    assertCount++;
    if (strobeSum() !== 0 || bus.ready !== 1'b1 || bus.valid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL midpush_async: got strobes=%0d ready=%b valid=%b want 0/1/0",
               strobeSum(), bus.ready, bus.valid);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    assertCount++;
    if (bus.ready !== 1'b1 || bus.cycles !== '0 || bus.valid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL midpush_after: got ready=%b cycles=%0d valid=%b want 1/0/0",
               bus.ready, bus.cycles, bus.valid);
    end
  endtask

  task automatic test_watchdog();
    int validCount;
    int readyAt;
    validCount = 0;
    readyAt    = -1;
    stuck        = 1'b1;
    bus.start    = 1'b1;
    bus.entry_in = SIZE'(5);
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.valid === 1'b1) validCount++;
      if (bus.ready === 1'b1 && readyAt < 0) begin
        readyAt = k;
        break;
      end
    end
    assertCount++;
    if (validCount !== 0) begin
      failCount++;
      $display("[TB] FAIL wd_no_valid: got %0d want 0", validCount);
    end
`ifdef CTRL_TIMEOUT_EN
    assertCount++;
    if (readyAt !== TIMEOUT + 1 || bus.error !== 1'b1 || bus.cycles !== CNT_W'(TIMEOUT)) begin
      failCount++;
      $display("[TB] FAIL wd_abort: got readyAt=%0d error=%b cycles=%0d want %0d/1/%0d",
               readyAt, bus.error, bus.cycles, TIMEOUT + 1, TIMEOUT);
    end
    stuck        = 1'b0;
    bus.start    = 1'b1;
    bus.entry_in = SIZE'(1);
    @(negedge clk);
    bus.start = 1'b0;
    assertCount++;
    if (bus.error !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL wd_error_clear: got %b want 0", bus.error);
    end
    repeat (3) @(negedge clk);
`else
    assertCount++;
    if (readyAt !== -1 || bus.error !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL wd_absent: got readyAt=%0d error=%b want -1/0", readyAt, bus.error);
    end
    rst = 1'b0;
    @(negedge clk);
    rst   = 1'b1;
    stuck = 1'b0;
    @(negedge clk);
`endif
  endtask

  initial begin
    assertCount  = 0;
    failCount    = 0;
    stuck        = 1'b0;
    bus.start    = 1'b0;
    bus.entry_in = '0;
    $display("[TB] starting recur_controller bench");
    test_reset();
    test_entry_zero();
    test_sequence();
    test_busy_start();
    test_random();
    test_back_to_back();
    test_reset_mid_push();
    test_watchdog();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
